// File: rtl/ibus_responder.sv
// -----------------------------------------------------------------------------
// ibus_responder
//
// Memory-side end of the instruction-fetch handshake. It accepts one fetch at a
// time, holds it for LATENCY cycles, and then returns the addressed 32-bit word
// from an internal word-addressed array. addr_ok and data_ok pulse together for
// exactly one cycle. A loader write port fills the array at any time.
//
// Ports
//   clk                  : single clock, all state updates on the rising edge
//   rst                  : synchronous, active-high reset (array is not reset)
//   ibus_req_valid_i     : fetch request qualifier
//   ibus_req_addr_i      : 64-bit byte address of the fetch
//   ibus_resp_addr_ok_o  : response strobe (always equal to data_ok)
//   ibus_resp_data_ok_o  : response strobe
//   ibus_resp_data_o     : fetched instruction word (held between responses)
//   err_o                : high in a response cycle whose address was bad
//   wr_en_i              : loader write strobe
//   wr_addr_i            : loader byte address (aligned and in range, else dropped)
//   wr_data_i            : loader write data
//
// Parameters
//   BASE_ADDR : byte address of array word 0 (defaults to the reset PC)
//   MEM_WORDS : number of 32-bit words in the array
//   LATENCY   : cycles from acceptance to response, 1..15
// -----------------------------------------------------------------------------
module ibus_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_req_valid_i,
    input  logic [63:0] ibus_req_addr_i,
    output logic        ibus_resp_addr_ok_o,
    output logic        ibus_resp_data_ok_o,
    output logic [31:0] ibus_resp_data_o,
    output logic        err_o,
    input  logic        wr_en_i,
    input  logic [63:0] wr_addr_i,
    input  logic [31:0] wr_data_i
);

    localparam int          IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [63:0] SPAN     = 64'(MEM_WORDS) << 2;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
    localparam logic        LAT_ONE  = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] la_q, la_d;
    logic        resp_q;
    logic        err_q;
    logic [31:0] data_q;

    // Set on the edge that enters RESP: that edge performs the array read.
    logic        rd_go;

    logic [31:0] mem_q [MEM_WORDS];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        la_d    = la_q;
        rd_go   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ibus_req_valid_i) begin
                    la_d  = ibus_req_addr_i;
                    cnt_d = CNT_LOAD;
                    if (LAT_ONE) begin
                        state_d = ST_RESP;
                        rd_go   = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!ibus_req_valid_i) begin
                    // Initiator withdrew the request: drop it silently.
                    state_d = ST_IDLE;
                end else if (ibus_req_addr_i != la_q) begin
                    // Redirect restarts the full latency from this edge.
                    la_d  = ibus_req_addr_i;
                    cnt_d = CNT_LOAD;
                    if (LAT_ONE) begin
                        state_d = ST_RESP;
                        rd_go   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RESP;
                        rd_go   = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                // The initiator still shows valid here; never sample it.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address decode for the read (uses the address being latched this edge,
    // so a same-edge accept/redirect with LATENCY==1 reads the new address)
    // and for the loader write.
    // -------------------------------------------------------------------------
    logic [63:0]      rd_off;
    logic             rd_ok;
    logic [IDX_W-1:0] rd_idx;
    logic [63:0]      wr_off;
    logic             wr_ok;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      rd_word;

    always_comb begin
        rd_off = la_d - BASE_ADDR;
        rd_ok  = (la_d[1:0] == 2'b00) && (la_d >= BASE_ADDR) && (rd_off < SPAN);
        rd_idx = IDX_W'(rd_off >> 2);

        wr_off = wr_addr_i - BASE_ADDR;
        wr_ok  = (wr_addr_i[1:0] == 2'b00) && (wr_addr_i >= BASE_ADDR) && (wr_off < SPAN);
        wr_idx = IDX_W'(wr_off >> 2);

        rd_word = 32'h0;
        if (rd_ok) begin
            // Write-first: a same-edge write to the read word wins.
            if (wr_en_i && wr_ok && (wr_idx == rd_idx)) begin
                rd_word = wr_data_i;
            end else begin
                rd_word = mem_q[rd_idx];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            la_q    <= 64'd0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            la_q    <= la_d;
            resp_q  <= rd_go;
            err_q   <= rd_go && !rd_ok;
            if (rd_go) begin
                data_q <= rd_word;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Instruction array (contents survive reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en_i && wr_ok) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    assign ibus_resp_addr_ok_o = resp_q;
    assign ibus_resp_data_ok_o = resp_q;
    assign ibus_resp_data_o    = data_q;
    assign err_o               = err_q;

endmodule

// File: tb/tb_ibus_responder.sv
// -----------------------------------------------------------------------------
// tb_ibus_responder
//
// Three responders with LATENCY 1, 2 and 3 run side by side, each with its own
// request and loader inputs. A reference array per instance tracks the loader
// writes; expected response timing is derived from the latency arithmetic.
// -----------------------------------------------------------------------------
module tb_ibus_responder;

    localparam logic [63:0] B  = 64'h0000_0000_8000_0000;
    localparam int          MW = 256;
    localparam int          NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        vld [NI];
    logic [63:0] adr [NI];
    logic        wen [NI];
    logic [63:0] wad [NI];
    logic [31:0] wdt [NI];
    logic        aok [NI];
    logic        dok [NI];
    logic        er  [NI];
    logic [31:0] dat [NI];

    logic [31:0] mem_m [NI][MW];

    int n_assert = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ibus_responder #(
            .BASE_ADDR (B),
            .MEM_WORDS (MW),
            .LATENCY   (g + 1)
        ) u_dut (
            .clk                 (clk),
            .rst                 (rst),
            .ibus_req_valid_i    (vld[g]),
            .ibus_req_addr_i     (adr[g]),
            .ibus_resp_addr_ok_o (aok[g]),
            .ibus_resp_data_ok_o (dok[g]),
            .ibus_resp_data_o    (dat[g]),
            .err_o               (er[g]),
            .wr_en_i             (wen[g]),
            .wr_addr_i           (wad[g]),
            .wr_data_i           (wdt[g])
        );
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a < B) || (a >= B + 64'(4 * MW));
    endfunction

    function automatic logic [31:0] exp_data(input int k, input logic [63:0] a);
        if (bad(a)) return 32'h0;
        return mem_m[k][int'((a - B) >> 2)];
    endfunction

    // Loader write; the reference array only changes for a legal address.
    task automatic write_word(input int k, input logic [63:0] a, input logic [31:0] d);
        wen[k] = 1'b1;
        wad[k] = a;
        wdt[k] = d;
        if (!bad(a)) mem_m[k][int'((a - B) >> 2)] = d;
        tick;
        wen[k] = 1'b0;
    endtask

    // Request already on the bus; the response must appear LATENCY cycles
    // after acceptance and at no earlier cycle.
    task automatic expect_resp(input int k, input logic [63:0] a, input string tag);
        for (int i = 0; i < k + 1; i++) begin
            tick;
            chk($sformatf("%s L%0d ok c%0d", tag, k + 1, i), 64'(aok[k]), 64'(i == k));
            chk($sformatf("%s L%0d dok c%0d", tag, k + 1, i), 64'(dok[k]), 64'(i == k));
        end
        chk($sformatf("%s L%0d data", tag, k + 1), 64'(dat[k]), 64'(exp_data(k, a)));
        chk($sformatf("%s L%0d err", tag, k + 1), 64'(er[k]), 64'(bad(a)));
    endtask

    task automatic fetch_hold(input int k, input logic [63:0] a, input string tag);
        vld[k] = 1'b1;
        adr[k] = a;
        expect_resp(k, a, tag);
        vld[k] = 1'b0;
        tick;
        chk($sformatf("%s L%0d ok after", tag, k + 1), 64'(aok[k]), 64'd0);
        chk($sformatf("%s L%0d err after", tag, k + 1), 64'(er[k]), 64'd0);
    endtask

    // Sequential fetches from the base address with valid held throughout.
    // Responses are due every LATENCY+1 cycles, first at cycle LATENCY-1.
    task automatic integ(input int k, input int nwords);
        int l;
        int n;
        int last;
        logic due;
        l    = k + 1;
        n    = 0;
        last = (l - 1) + (l + 1) * (nwords - 1);
        vld[k] = 1'b1;
        adr[k] = B;
        for (int cyc = 0; cyc <= last + 1; cyc++) begin
            tick;
            due = (cyc >= l - 1) && (((cyc - (l - 1)) % (l + 1)) == 0);
            chk($sformatf("integ L%0d ok c%0d", l, cyc), 64'(aok[k]), 64'(due));
            if (aok[k]) begin
                chk($sformatf("integ L%0d word%0d", l, n), 64'(dat[k]), 64'(exp_data(k, B + 64'(4 * n))));
                n++;
                adr[k] = B + 64'(4 * n);
            end
        end
        vld[k] = 1'b0;
        chk($sformatf("integ L%0d count", l), 64'(n), 64'(nwords));
        for (int i = 0; i < l + 2; i++) begin
            tick;
            chk($sformatf("integ L%0d drain", l), 64'(aok[k]), 64'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        int          sel;

        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            vld[k] = 1'b0;
            adr[k] = '0;
            wen[k] = 1'b0;
            wad[k] = '0;
            wdt[k] = '0;
        end
        tick;
        tick;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset L%0d ok", k + 1), 64'(aok[k]), 64'd0);
            chk($sformatf("reset L%0d dok", k + 1), 64'(dok[k]), 64'd0);
            chk($sformatf("reset L%0d err", k + 1), 64'(er[k]), 64'd0);
            chk($sformatf("reset L%0d data", k + 1), 64'(dat[k]), 64'd0);
        end
        rst = 1'b0;

        // Preload every word of every instance.
        for (int i = 0; i < MW; i++) begin
            for (int k = 0; k < NI; k++) begin
                wen[k] = 1'b1;
                wad[k] = B + 64'(4 * i);
                if (i == 0) wdt[k] = 32'h0000_0013;
                else if (i == 16) wdt[k] = 32'hDEAD_BEEF;
                else wdt[k] = $urandom;
                mem_m[k][i] = wdt[k];
            end
            tick;
        end
        for (int k = 0; k < NI; k++) wen[k] = 1'b0;

        // Illegal loader writes must not touch the array.
        write_word(1, B + 64'd1, 32'hBAD0_0001);
        write_word(1, B + 64'(4 * MW), 32'hBAD0_0002);

        // Basic fetch on every latency.
        for (int k = 0; k < NI; k++) fetch_hold(k, B, "basic");

        // Redirect one cycle after acceptance.
        for (int k = 1; k < NI; k++) begin
            vld[k] = 1'b1;
            adr[k] = B + 64'd8;
            tick;
            chk($sformatf("redir L%0d ok pre", k + 1), 64'(aok[k]), 64'd0);
            adr[k] = B + 64'h40;
            expect_resp(k, B + 64'h40, "redir");
            vld[k] = 1'b0;
            tick;
            chk($sformatf("redir L%0d single", k + 1), 64'(aok[k]), 64'd0);
        end

        // Abort in WAIT, then the same address must take the full latency.
        for (int k = 1; k < NI; k++) begin
            vld[k] = 1'b1;
            adr[k] = B + 64'd4;
            tick;
            vld[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick;
                chk($sformatf("abort L%0d quiet", k + 1), 64'(aok[k]), 64'd0);
            end
            fetch_hold(k, B + 64'd4, "post-abort");
        end

        // Reset during WAIT discards the request.
        vld[2] = 1'b1;
        adr[2] = B + 64'd16;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vld[2] = 1'b0;
        chk("rst-wait ok", 64'(aok[2]), 64'd0);
        chk("rst-wait dok", 64'(dok[2]), 64'd0);
        chk("rst-wait err", 64'(er[2]), 64'd0);
        chk("rst-wait data", 64'(dat[2]), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rst-wait quiet", 64'(aok[2]), 64'd0);
        end
        fetch_hold(2, B + 64'd16, "post-rst");

        // Misaligned, past the end, and below the base.
        for (int k = 0; k < NI; k++) begin
            fetch_hold(k, B + 64'd2, "misalign");
            fetch_hold(k, B + 64'(4 * MW), "oor-hi");
            fetch_hold(k, B - 64'd4, "oor-lo");
        end

        // Write to the requested word on the read edge.
        for (int k = 0; k < NI; k++) begin
            vld[k] = 1'b1;
            adr[k] = B + 64'd20;
            for (int i = 0; i < k + 1; i++) begin
                if (i == k) begin
                    wen[k] = 1'b1;
                    wad[k] = B + 64'd20;
                    wdt[k] = 32'hCAFE_F00D;
                    mem_m[k][5] = 32'hCAFE_F00D;
                end
                tick;
                wen[k] = 1'b0;
                chk($sformatf("wfirst L%0d ok c%0d", k + 1, i), 64'(aok[k]), 64'(i == k));
            end
            chk($sformatf("wfirst L%0d data", k + 1), 64'(dat[k]), 64'h0000_0000_CAFE_F00D);
            vld[k] = 1'b0;
            tick;
        end

        // Fetch-stage style streams.
        integ(0, 8);
        integ(2, 8);
        integ(1, 6);

        // Randomized loader writes and fetches.
        for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < 10; r++) begin
                write_word(k, B + 64'(4 * $urandom_range(0, MW - 1)), $urandom);
                if ((r % 3) == 0) write_word(k, B + 64'(4 * $urandom_range(0, MW - 1)) + 64'd2, $urandom);
                sel = int'($urandom_range(0, 9));
                if (sel < 7) a = B + 64'(4 * $urandom_range(0, MW - 1));
                else if (sel == 7) a = B + 64'(4 * $urandom_range(0, MW - 1)) + 64'($urandom_range(1, 3));
                else if (sel == 8) a = B + 64'(4 * MW) + 64'(4 * $urandom_range(0, 15));
                else a = B - 64'(4 * $urandom_range(1, 16));
                fetch_hold(k, a, "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
